// File: rtl/vend_if.sv
// Coin, dispenser handshake and status signals shared between the vend arbiter
// and its environment (coin slots, dispenser mechanism).
interface vend_if;
  logic [1:0] coin_a;
  logic [1:0] coin_b;
  logic       disp_req;
  logic       disp_ack;
  logic       grant_b;
  logic       newspaper_a;
  logic       newspaper_b;
  logic [3:0] stock;
  logic       sold_out;

  modport master (
    input  coin_a, coin_b, disp_ack,
    output disp_req, grant_b, newspaper_a, newspaper_b, stock, sold_out
  );

  modport slave (
    output coin_a, coin_b, disp_ack,
    input  disp_req, grant_b, newspaper_a, newspaper_b, stock, sold_out
  );
endinterface

// File: rtl/vend_arbiter.sv
// Two-slot newspaper vending arbiter: accumulates per-slot credit and shares one
// dispenser between slots A and B using round-robin on simultaneous eligibility.
module vend_arbiter #(
  parameter int PRICE      = 3,
  parameter int STOCK_INIT = 8
) (
  input  logic   clock,
  input  logic   reset,
  vend_if.master bus
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [2:0] PRICE_C = 3'(PRICE);
  localparam logic [3:0] STOCK_C = 4'(STOCK_INIT);

  logic [1:0] state_r;
  logic [2:0] credit_a_r;
  logic [2:0] credit_b_r;
  logic       rr_r;
  logic [3:0] stock_r;
  logic       disp_req_r;
  logic       grant_b_r;
  logic       newspaper_a_r;
  logic       newspaper_b_r;
  logic       sold_out_r;

  logic       elig_a_s;
  logic       elig_b_s;
  logic       pick_b_s;
  logic       vend_s;
  logic [2:0] credit_a_nxt_s;
  logic [2:0] credit_b_nxt_s;

  function automatic logic [2:0] coin_value(input logic [1:0] coin);
    case (coin)
      2'd1:    coin_value = 3'd1;
      2'd2:    coin_value = 3'd2;
      default: coin_value = 3'd0;
    endcase
  endfunction

  function automatic logic [2:0] sat_add(input logic [2:0] credit, input logic [2:0] add);
    logic [3:0] sum;
    sum = {1'b0, credit} + {1'b0, add};
    if (sum > 4'd7) begin
      sat_add = 3'd7;
    end else begin
      sat_add = sum[2:0];
    end
  endfunction

  // Eligibility, arbitration winner and next credit values
  always_comb begin
    elig_a_s = (credit_a_r >= PRICE_C) && (stock_r != 4'd0);
    elig_b_s = (credit_b_r >= PRICE_C) && (stock_r != 4'd0);
    if (elig_a_s && elig_b_s) begin
      pick_b_s = rr_r;
    end else begin
      pick_b_s = elig_b_s;
    end
    vend_s = (state_r == ST_REQ) && bus.disp_ack;

    // A coin landing on the vend edge seeds the freshly cleared credit
    if (sold_out_r) begin
      credit_a_nxt_s = credit_a_r;
    end else if (vend_s && !grant_b_r) begin
      credit_a_nxt_s = coin_value(bus.coin_a);
    end else begin
      credit_a_nxt_s = sat_add(credit_a_r, coin_value(bus.coin_a));
    end

    if (sold_out_r) begin
      credit_b_nxt_s = credit_b_r;
    end else if (vend_s && grant_b_r) begin
      credit_b_nxt_s = coin_value(bus.coin_b);
    end else begin
      credit_b_nxt_s = sat_add(credit_b_r, coin_value(bus.coin_b));
    end
  end

  // Per-slot credit registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      credit_a_r <= 3'd0;
      credit_b_r <= 3'd0;
    end else begin
      credit_a_r <= credit_a_nxt_s;
      credit_b_r <= credit_b_nxt_s;
    end
  end

  // Vend sequencing, stock, round-robin pointer and registered outputs
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r       <= ST_IDLE;
      rr_r          <= 1'b0;
      stock_r       <= STOCK_C;
      disp_req_r    <= 1'b0;
      grant_b_r     <= 1'b0;
      newspaper_a_r <= 1'b0;
      newspaper_b_r <= 1'b0;
      sold_out_r    <= 1'b0;
    end else begin
      newspaper_a_r <= 1'b0;
      newspaper_b_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (elig_a_s || elig_b_s) begin
            state_r    <= ST_REQ;
            grant_b_r  <= pick_b_s;
            disp_req_r <= 1'b1;
          end
        end
        ST_REQ: begin
          if (bus.disp_ack) begin
            state_r       <= ST_DONE;
            disp_req_r    <= 1'b0;
            stock_r       <= stock_r - 4'd1;
            sold_out_r    <= (stock_r == 4'd1);
            rr_r          <= ~grant_b_r;
            newspaper_a_r <= ~grant_b_r;
            newspaper_b_r <= grant_b_r;
          end
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
        end
        default: begin
          state_r    <= ST_IDLE;
          disp_req_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.disp_req    = disp_req_r;
  assign bus.grant_b     = grant_b_r;
  assign bus.newspaper_a = newspaper_a_r;
  assign bus.newspaper_b = newspaper_b_r;
  assign bus.stock       = stock_r;
  assign bus.sold_out    = sold_out_r;

endmodule

// File: tb/tb_vend_arbiter.sv
// Bench for vend_arbiter: two instances (STOCK_INIT 8 and 1) share one stimulus
// stream and are compared cycle by cycle against a transaction-level model.
module tb_vend_arbiter;

  localparam int PRICE = 3;

  logic       clock;
  logic       reset;
  logic [1:0] coin_a;
  logic [1:0] coin_b;
  logic       ack;

  int n_checks;
  int n_errors;

  vend_if bus0 ();
  vend_if bus1 ();

  assign bus0.coin_a   = coin_a;
  assign bus0.coin_b   = coin_b;
  assign bus0.disp_ack = ack;
  assign bus1.coin_a   = coin_a;
  assign bus1.coin_b   = coin_b;
  assign bus1.disp_ack = ack;

  vend_arbiter #(.PRICE(PRICE), .STOCK_INIT(8)) dut0 (.clock(clock), .reset(reset), .bus(bus0));
  vend_arbiter #(.PRICE(PRICE), .STOCK_INIT(1)) dut1 (.clock(clock), .reset(reset), .bus(bus1));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Model: per instance, credits per slot, stock, rr, pending owner, pulse owner
  int stock_init [2] = '{8, 1};
  int m_credit [2][2];
  int m_stock [2];
  int m_rr [2];
  int m_owner [2];
  int m_pulse [2];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (got !== exp) begin
      n_errors = n_errors + 1;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int coin_val(input logic [1:0] c);
    if (c == 2'd1) return 1;
    if (c == 2'd2) return 2;
    return 0;
  endfunction

  task automatic model_reset(input int i);
    m_credit[i][0] = 0;
    m_credit[i][1] = 0;
    m_stock[i] = stock_init[i];
    m_rr[i] = 0;
    m_owner[i] = -1;
    m_pulse[i] = -1;
  endtask

  task automatic model_step(input int i, input logic [1:0] ca, input logic [1:0] cb, input logic a);
    int  cv [2];
    bit  el [2];
    bit  vend;
    bit  idle;
    int  win;
    int  sum;
    cv[0] = coin_val(ca);
    cv[1] = coin_val(cb);
    vend = (m_owner[i] >= 0) && a;
    idle = (m_owner[i] < 0) && (m_pulse[i] < 0);
    for (int s = 0; s < 2; s++) el[s] = (m_credit[i][s] >= PRICE) && (m_stock[i] > 0);
    win = -1;
    if (el[0] && el[1]) win = m_rr[i];
    else if (el[0]) win = 0;
    else if (el[1]) win = 1;
    for (int s = 0; s < 2; s++) begin
      if (m_stock[i] > 0) begin
        if (vend && s == m_owner[i]) begin
          m_credit[i][s] = cv[s];
        end else begin
          sum = m_credit[i][s] + cv[s];
          m_credit[i][s] = (sum > 7) ? 7 : sum;
        end
      end
    end
    m_pulse[i] = vend ? m_owner[i] : -1;
    if (vend) begin
      m_stock[i] = m_stock[i] - 1;
      m_rr[i] = 1 - m_owner[i];
      m_owner[i] = -1;
    end else if (idle && win >= 0) begin
      m_owner[i] = win;
    end
  endtask

  task automatic compare(input int i, input logic req, input logic gb, input logic na,
                         input logic nb, input logic [3:0] st, input logic so);
    string p;
    p = (i == 0) ? "u0" : "u1";
    check_eq({p, "_disp_req"}, req, (m_owner[i] >= 0) ? 1 : 0);
    if (m_owner[i] >= 0) check_eq({p, "_grant_b"}, gb, m_owner[i]);
    check_eq({p, "_newspaper_a"}, na, (m_pulse[i] == 0) ? 1 : 0);
    check_eq({p, "_newspaper_b"}, nb, (m_pulse[i] == 1) ? 1 : 0);
    check_eq({p, "_news_excl"}, na & nb, 0);
    check_eq({p, "_stock"}, st, m_stock[i]);
    check_eq({p, "_sold_out"}, so, (m_stock[i] == 0) ? 1 : 0);
  endtask

  task automatic compare_all();
    compare(0, bus0.disp_req, bus0.grant_b, bus0.newspaper_a, bus0.newspaper_b, bus0.stock, bus0.sold_out);
    compare(1, bus1.disp_req, bus1.grant_b, bus1.newspaper_a, bus1.newspaper_b, bus1.stock, bus1.sold_out);
  endtask

  task automatic cycle(input logic [1:0] ca, input logic [1:0] cb, input logic a);
    coin_a = ca;
    coin_b = cb;
    ack = a;
    @(posedge clock);
    model_step(0, ca, cb, a);
    model_step(1, ca, cb, a);
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    coin_a = 2'd0;
    coin_b = 2'd0;
    ack = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    // Reset acts immediately, before any clock edge
    check_eq("rst_disp_req_u0", bus0.disp_req, 0);
    check_eq("rst_disp_req_u1", bus1.disp_req, 0);
    check_eq("rst_stock_u0", bus0.stock, 8);
    check_eq("rst_stock_u1", bus1.stock, 1);
    model_reset(0);
    model_reset(1);
    @(posedge clock);
    #1;
    reset = 1'b0;
    compare_all();
  endtask

  function automatic logic [1:0] rand_coin();
    int r;
    r = $urandom_range(0, 9);
    if (r < 6) return 2'd0;
    if (r < 8) return 2'd1;
    if (r < 9) return 2'd2;
    return 2'd3;
  endfunction

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset = 1'b1;
    coin_a = 2'd0;
    coin_b = 2'd0;
    ack = 1'b0;
    model_reset(0);
    model_reset(1);
    repeat (2) @(posedge clock);
    #1;
    compare_all();
    reset = 1'b0;

    // Slot A: three nickels, ack two cycles after the request
    cycle(2'd1, 2'd0, 1'b0);
    cycle(2'd0, 2'd0, 1'b0);
    cycle(2'd1, 2'd0, 1'b0);
    cycle(2'd0, 2'd0, 1'b0);
    cycle(2'd1, 2'd0, 1'b0);
    cycle(2'd0, 2'd0, 1'b0);
    check_eq("a_req_rises", bus0.disp_req, 1);
    check_eq("a_grant", bus0.grant_b, 0);
    cycle(2'd0, 2'd0, 1'b0);
    cycle(2'd0, 2'd0, 1'b1);
    check_eq("a_pulse", bus0.newspaper_a, 1);
    cycle(2'd0, 2'd0, 1'b0);
    check_eq("a_stock7", bus0.stock, 7);
    check_eq("u1_sold_out", bus1.sold_out, 1);

    // Slot B: two dimes, surplus nickel forfeited
    cycle(2'd0, 2'd2, 1'b0);
    cycle(2'd0, 2'd2, 1'b0);
    repeat (3) cycle(2'd0, 2'd0, 1'b0);
    cycle(2'd0, 2'd0, 1'b1);
    check_eq("b_pulse", bus0.newspaper_b, 1);
    repeat (4) cycle(2'd0, 2'd0, 1'b0);
    check_eq("b_no_rerequest", bus0.disp_req, 0);

    // Invalid coins and stray acks while idle
    repeat (5) cycle(2'd3, 2'd3, 1'b1);
    check_eq("inv_no_vend", bus0.stock, 6);

    // Both slots become eligible together: A first, then B
    do_reset();
    repeat (3) cycle(2'd1, 2'd1, 1'b0);
    repeat (10) cycle(2'd0, 2'd0, 1'b1);
    check_eq("both_stock6", bus0.stock, 6);

    // Randomized traffic with occasional resets, some during an open request
    for (int n = 0; n < 3000; n++) begin
      if ((m_owner[0] >= 0 && $urandom_range(0, 40) == 0) || (n % 400 == 399)) begin
        do_reset();
      end else begin
        cycle(rand_coin(), rand_coin(), ($urandom_range(0, 2) == 0));
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
